// File: rtl/key_pkg.sv
// Shared definitions for the key press classifier: FSM state encoding and
// default cycle counts for a 50 MHz system clock.
package key_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_LONG  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StPress = ST_PRESS,
        StLong  = ST_LONG
    } key_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYC = 200_000;     // 4 ms
    localparam int unsigned DEF_LONG_CYC     = 50_000_000;  // 1 s
    localparam int unsigned DEF_REPEAT_CYC   = 0;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a debouncer: key_db follows the synchronised
// key only after it has disagreed for DEBOUNCE_CYC consecutive cycles.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_db
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYC - 1);

    if (DEBOUNCE_CYC < 1) begin : g_param_check
        $error("key_debounce: DEBOUNCE_CYC must be >= 1");
    end

    logic          sync_q;
    logic          key_s_q;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          key_db_q, key_db_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 1'b1;
            key_s_q  <= 1'b1;
            dcnt_q   <= '0;
            key_db_q <= 1'b1;
        end else begin
            sync_q   <= key_in;
            key_s_q  <= sync_q;
            dcnt_q   <= dcnt_d;
            key_db_q <= key_db_d;
        end
    end

    // Any cycle of agreement restarts the count, so short glitches are dropped.
    always_comb begin
        key_db_d = key_db_q;
        dcnt_d   = '0;
        if (key_s_q != key_db_q) begin
            if (dcnt_q == DCNT_LAST) begin
                key_db_d = key_s_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    assign key_db = key_db_q;

endmodule

// File: rtl/key_press_classify.sv
// Debounced key front-end that classifies each press as short or long and
// emits one-cycle strobes, with optional auto-repeat of the long strobe.
module key_press_classify
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
    parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_short,
    output logic key_long,
    output logic key_hold
);

    localparam int unsigned HW = $clog2(LONG_CYC + 1);
    localparam int unsigned RW = (REPEAT_CYC > 0) ? $clog2(REPEAT_CYC + 1) : 1;
    localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYC - 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);

    if (DEBOUNCE_CYC < 1 || LONG_CYC < 2) begin : g_param_check
        $error("key_press_classify: need DEBOUNCE_CYC >= 1 and LONG_CYC >= 2");
    end

    logic          key_db;
    key_state_e    state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          short_q, short_d;
    logic          long_q, long_d;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_in),
        .key_db (key_db)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hcnt_q  <= '0;
            rcnt_q  <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            rcnt_q  <= rcnt_d;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

    assign hcnt_inc = (hcnt_q == HCNT_LAST) ? hcnt_q : hcnt_q + HW'(1);

    // Release is tested before the threshold so a tie resolves to a short press.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        rcnt_d  = rcnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!key_db) begin
                    state_d = StPress;
                    hcnt_d  = '0;
                end
            end
            StPress: begin
                hcnt_d = hcnt_inc;
                if (key_db) begin
                    short_d = 1'b1;
                    state_d = StIdle;
                end else if (hcnt_inc == HCNT_LAST) begin
                    long_d  = 1'b1;
                    state_d = StLong;
                    rcnt_d  = '0;
                end
            end
            StLong: begin
                if (key_db) begin
                    state_d = StIdle;
                end else if (REPEAT_CYC > 0) begin
                    if (rcnt_q == RCNT_LAST) begin
                        long_d = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign key_short = short_q;
    assign key_long  = long_q;
    assign key_hold  = ~key_db;

endmodule

// File: tb/tb_key_press_classify.sv
// Bench for key_press_classify: two instances (no repeat / repeat every 8) driven by
// directed and random key traces, checked each cycle against a press-duration model.
module tb_key_press_classify;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LNG  = 20;
    localparam int unsigned REP1 = 8;
    localparam int          MAXE = 8192;

    logic clk = 1'b0;
    logic rst_n;
    logic key_in;
    logic s0, l0, h0, s1, l1, h1;

    always #5 clk = ~clk;

    key_press_classify #(
        .DEBOUNCE_CYC (DEB),
        .LONG_CYC     (LNG),
        .REPEAT_CYC   (0)
    ) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_short (s0),
        .key_long  (l0),
        .key_hold  (h0)
    );

    key_press_classify #(
        .DEBOUNCE_CYC (DEB),
        .LONG_CYC     (LNG),
        .REPEAT_CYC   (REP1)
    ) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_short (s1),
        .key_long  (l1),
        .key_hold  (h1)
    );

    int tests = 0;
    int fails = 0;
    int e     = 0;   // clock edges seen with reset released
    int base  = 1;   // first edge after the latest reset release
    int press_at = -1;
    bit kin[MAXE];
    bit ks[MAXE];
    bit kdb[MAXE];
    int n_short0, n_long0, n_short1, n_long1, n_hold0;
    int seg_start, first_hold, first_short, first_long;

    function automatic bit ks_at(int j);
        return (j >= base) ? ks[j] : 1'b1;
    endfunction

    function automatic bit kdb_at(int j);
        return (j >= base) ? kdb[j] : 1'b1;
    endfunction

    // Short strobe one edge after a release that ended a press held under LNG edges.
    function automatic bit exp_short(int ed);
        if (press_at < 0) return 1'b0;
        if (!(kdb_at(ed - 1) && !kdb_at(ed - 2))) return 1'b0;
        return (ed - 1 - press_at) < int'(LNG);
    endfunction

    // Long strobe at hold LNG and every rep after it, while the key is still down.
    function automatic bit exp_long(int rep, int ed);
        int held;
        if (press_at < 0 || kdb_at(ed - 1)) return 1'b0;
        held = ed - press_at;
        if (held == int'(LNG)) return 1'b1;
        if (rep > 0 && held > int'(LNG) && ((held - int'(LNG)) % rep) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b at edge %0d", tag, got, exp, e);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        tests++;
        assert (got == exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_short0 = 0; n_long0 = 0; n_short1 = 0; n_long1 = 0; n_hold0 = 0;
        seg_start = e;
        first_hold = -1; first_short = -1; first_long = -1;
    endtask

    task automatic step();
        bit cur, flip, es, el0, el1;
        @(posedge clk);
        e++;
        kin[e] = key_in;
        ks[e]  = (e - 1 >= base) ? kin[e - 1] : 1'b1;
        // Debounced level flips once the last DEB synchronised samples all disagree.
        cur  = kdb_at(e - 1);
        flip = 1'b1;
        for (int j = e - int'(DEB); j < e; j++) begin
            if (ks_at(j) == cur) flip = 1'b0;
        end
        kdb[e] = flip ? ~cur : cur;
        es  = exp_short(e);
        el0 = exp_long(0, e);
        el1 = exp_long(int'(REP1), e);
        if (kdb_at(e - 1) && !kdb[e]) press_at = e;
        #1;
        check("hold0", h0, ~kdb[e]);
        check("short0", s0, es);
        check("long0", l0, el0);
        check("hold1", h1, ~kdb[e]);
        check("short1", s1, es);
        check("long1", l1, el1);
        n_short0 += int'(s0); n_long0 += int'(l0);
        n_short1 += int'(s1); n_long1 += int'(l1);
        n_hold0  += int'(h0);
        if (h0 && first_hold < 0)  first_hold  = e;
        if (s0 && first_short < 0) first_short = e;
        if (l0 && first_long < 0)  first_long  = e;
    endtask

    task automatic drive(input bit v, input int n);
        key_in = v;
        repeat (n) step();
    endtask

    initial begin
        rst_n  = 1'b0;
        key_in = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        check("rst_hold", h0, 1'b0);
        check("rst_short", s0, 1'b0);
        check("rst_long", l0, 1'b0);
        drive(1'b1, 5);

        // Glitch shorter than the debounce window
        clear_counts();
        drive(1'b0, 3);
        drive(1'b1, 30);
        check_int("glitch_hold", n_hold0, 0);
        check_int("glitch_strobes", n_short0 + n_long0, 0);

        // Short press: hold 6 after the fall, short 7 after the rise
        clear_counts();
        drive(1'b0, 10);
        drive(1'b1, 30);
        check_int("short_hold_lat", first_hold - seg_start, 6);
        check_int("short_strobe_lat", first_short - (seg_start + 10), 7);
        check_int("short_count", n_short0, 1);
        check_int("short_nolong", n_long0, 0);

        // Long press: single long 20 cycles into the hold
        clear_counts();
        drive(1'b0, 40);
        drive(1'b1, 30);
        check_int("long_lat", first_long - first_hold, 20);
        check_int("long_count", n_long0, 1);
        check_int("long_noshort", n_short0, 0);

        // Auto-repeat: hold 50 gives longs at 20, 28, 36, 44
        clear_counts();
        drive(1'b0, 50);
        drive(1'b1, 30);
        check_int("repeat_count", n_long1, 4);
        check_int("repeat_noshort", n_short1, 0);
        check_int("norepeat_count", n_long0, 1);

        // Boundary: 19-cycle hold is short, 20-cycle hold is long
        clear_counts();
        drive(1'b0, 19);
        drive(1'b1, 30);
        check_int("bound19_short", n_short0, 1);
        check_int("bound19_long", n_long0, 0);
        clear_counts();
        drive(1'b0, 20);
        drive(1'b1, 30);
        check_int("bound20_short", n_short0, 0);
        check_int("bound20_long", n_long0, 1);

        // Reset at hold 10 with the key still down
        clear_counts();
        drive(1'b0, 16);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_hold0", h0, 1'b0);
        check("midrst_hold1", h1, 1'b0);
        check("midrst_short", s0, 1'b0);
        check("midrst_long", l0, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        base = e + 1;
        press_at = -1;
        clear_counts();
        drive(1'b0, 30);
        drive(1'b1, 30);
        check_int("postrst_hold_lat", first_hold - seg_start, 6);
        check_int("postrst_long", n_long0, 1);
        check_int("postrst_short", n_short0, 0);

        // Bounce, then a clean 12-cycle press
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2);
            drive(1'b1, 2);
        end
        drive(1'b0, 12);
        drive(1'b1, 30);
        check_int("bounce_presses", n_short0 + n_long0, 1);
        check_int("bounce_short", n_short0, 1);

        // Random press/gap lengths, checked cycle by cycle against the model
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, int'($urandom_range(1, 45)));
            drive(1'b1, int'($urandom_range(1, 12)));
        end
        drive(1'b1, 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
